// File: rtl/jt51_cpu_fifo.sv
// JT51 CPU write interface: P1-rate clock enable, DEPTH-entry write FIFO drained into mmr, status byte.
// Optional JT51_FIFO_STATUS_EN exposes full/overflow bits in d_out[6:5].
module jt51_cpu_fifo #(
    parameter int DEPTH   = 8,
    parameter int CEN_DIV = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cs_n,
    input  logic                        wr_n,
    input  logic                        a0,
    input  logic [7:0]                  d_in,
    input  logic                        flag_A,
    input  logic                        flag_B,
    output logic [7:0]                  d_out,
    output logic                        cen,
    output logic                        mmr_write,
    output logic                        mmr_a0,
    output logic [7:0]                  mmr_d,
    input  logic                        mmr_busy,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CEN_DIV);

    // Handshake: a push is the rising edge of the CPU write strobe; mmr takes an
    // entry while mmr_write is high and answers a data write by raising mmr_busy.
    typedef enum logic [1:0] {IDLE, PRESENT, WAIT_HI, WAIT_LO} state_t;

    state_t         state, state_nx;
    logic           to_cnt, to_nx;
    logic           mw_nx;
    logic [CW-1:0]  cnt;
    logic           wr, wr_l, push_req, push, pop, full;
    logic [AW-1:0]  wptr, rptr;
    logic [8:0]     mem [DEPTH];
    logic           flag_a_r, flag_b_r;
    logic           st_full, st_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            cen <= 1'b0;
        end else if (cnt == CW'(CEN_DIV - 1)) begin
            cnt <= '0;
            cen <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            cen <= 1'b0;
        end
    end

    assign wr       = !cs_n && !wr_n;
    assign push_req = wr && !wr_l;
    assign full     = (level == (AW+1)'(DEPTH));
    // A push into a full FIFO is lost even when a pop frees a slot that same clk.
    assign push     = push_req && !full;
    assign pop      = cen && (state == IDLE) && (level != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {a0, d_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_l  <= 1'b0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wr_l <= wr;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            to_cnt    <= 1'b0;
            mmr_write <= 1'b0;
            mmr_a0    <= 1'b0;
            mmr_d     <= '0;
        end else begin
            state     <= state_nx;
            to_cnt    <= to_nx;
            mmr_write <= mw_nx;
            if (pop) {mmr_a0, mmr_d} <= mem[rptr];
        end
    end

    always_comb begin
        state_nx = state;
        to_nx    = to_cnt;
        mw_nx    = mmr_write;
        if (cen) begin
            case (state)
                IDLE: begin
                    if (level != '0) begin
                        state_nx = PRESENT;
                        mw_nx    = 1'b1;
                    end
                end
                PRESENT: begin
                    mw_nx    = 1'b0;
                    to_nx    = 1'b0;
                    state_nx = mmr_a0 ? WAIT_HI : IDLE;
                end
                // Give mmr two cen to acknowledge a data write before moving on.
                WAIT_HI: begin
                    if (mmr_busy)    state_nx = WAIT_LO;
                    else if (to_cnt) state_nx = IDLE;
                    else             to_nx    = 1'b1;
                end
                WAIT_LO: begin
                    if (!mmr_busy) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_a_r <= 1'b0;
            flag_b_r <= 1'b0;
        end else begin
            flag_a_r <= flag_A;
            flag_b_r <= flag_B;
        end
    end

`ifdef JT51_FIFO_STATUS_EN
    logic ovf;
    logic status_rd;

    assign status_rd = !cs_n && wr_n && !a0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  ovf <= 1'b0;
        else if (push_req && full)   ovf <= 1'b1;
        else if (status_rd)          ovf <= 1'b0;
    end

    assign st_full = full;
    assign st_ovf  = ovf;
`else
    assign st_full = 1'b0;
    assign st_ovf  = 1'b0;
`endif

    assign busy  = (level != '0) || (state != IDLE);
    assign d_out = {busy, st_full, st_ovf, 3'b000, flag_b_r, flag_a_r};

endmodule
